// File: rtl/fft_pkg.sv
// Shared defaults and fixed-point helpers for the FFT butterfly slice.
package fft_pkg;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned I_DEF    = 4;
  localparam int unsigned F_DEF    = 4;
  localparam int unsigned CMUL_LAT = 3;

  // Clamp a sign-extended value to the signed range of an n-bit word.
  function automatic logic signed [31:0] sat_n(input logic signed [32:0] v,
                                               input int unsigned n);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (n - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (n - 1));
    if (v > hi)      return 32'(hi);
    else if (v < lo) return 32'(lo);
    else             return 32'(v);
  endfunction

  // Halve with round-half-up: (v + 1) >>> 1.
  function automatic logic signed [31:0] rnd_shr1(input logic signed [32:0] v);
    logic signed [32:0] t;
    t = (v + 33'sd1) >>> 1;
    return 32'(t);
  endfunction

endpackage

// File: rtl/fft_butterfly_if.sv
// Data/handshake bundle between the stage controller and fft_butterfly.
interface fft_butterfly_if import fft_pkg::*; #(
  parameter int unsigned N = N_DEF
);
  logic         i_en;
  logic         i_valid;
  logic [N-1:0] i_a_re;
  logic [N-1:0] i_a_im;
  logic [N-1:0] i_bw_re;
  logic [N-1:0] i_bw_im;
  logic         i_clr_ovf;
  logic         o_valid;
  logic [N-1:0] o_x0_re;
  logic [N-1:0] o_x0_im;
  logic [N-1:0] o_x1_re;
  logic [N-1:0] o_x1_im;
  logic         o_ovf;

  modport master (
    output i_en, i_valid, i_a_re, i_a_im, i_bw_re, i_bw_im, i_clr_ovf,
    input  o_valid, o_x0_re, o_x0_im, o_x1_re, o_x1_im, o_ovf
  );

  modport slave (
    input  i_en, i_valid, i_a_re, i_a_im, i_bw_re, i_bw_im, i_clr_ovf,
    output o_valid, o_x0_re, o_x0_im, o_x1_re, o_x1_im, o_ovf
  );
endinterface

// File: rtl/cplx_delay_line.sv
// Enable-gated shift register that aligns operand A with the multiplier output.
module cplx_delay_line import fft_pkg::*; #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = CMUL_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (i_en) begin
      sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign o_d = sr[DEPTH-1];

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X0 = A + BW, X1 = A - BW in signed QI.F.
// Build macro FFT_BFLY_SCALE_EN selects halving with rounding instead of saturation.
module fft_butterfly import fft_pkg::*; #(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned I   = I_DEF,
  parameter int unsigned F   = F_DEF,
  parameter int unsigned LAT = CMUL_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_butterfly_if.slave  bus
);

  localparam int unsigned DW = 2 * N + 1;

  if ((I + F != N) || (LAT < 1) || (LAT > 8)) begin : g_bad_cfg
    $error("fft_butterfly: illegal parameter set");
  end

  logic [DW-1:0] dly_q;
  logic          d_valid;
  logic [N-1:0]  d_re;
  logic [N-1:0]  d_im;

  cplx_delay_line #(.W(DW), .DEPTH(LAT)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (bus.i_en),
    .i_d   ({bus.i_valid, bus.i_a_re, bus.i_a_im}),
    .o_d   (dly_q)
  );

  assign {d_valid, d_re, d_im} = dly_q;

  logic signed [N:0] s0_re, s0_im, s1_re, s1_im;
  logic              sat_any;

  always_comb begin
    s0_re = {d_re[N-1], d_re} + {bus.i_bw_re[N-1], bus.i_bw_re};
    s0_im = {d_im[N-1], d_im} + {bus.i_bw_im[N-1], bus.i_bw_im};
    s1_re = {d_re[N-1], d_re} - {bus.i_bw_re[N-1], bus.i_bw_re};
    s1_im = {d_im[N-1], d_im} - {bus.i_bw_im[N-1], bus.i_bw_im};
  end

  function automatic logic [N-1:0] post(input logic signed [N:0] s);
    logic signed [31:0] t;
`ifdef FFT_BFLY_SCALE_EN
    t = rnd_shr1(33'(s));
`else
    t = sat_n(33'(s), N);
`endif
    return N'(t);
  endfunction

`ifdef FFT_BFLY_SCALE_EN
  assign sat_any = 1'b0;
`else
  // An (N+1)-bit sum fits in N bits iff its top two bits agree.
  assign sat_any = (s0_re[N] ^ s0_re[N-1]) | (s0_im[N] ^ s0_im[N-1]) |
                   (s1_re[N] ^ s1_re[N-1]) | (s1_im[N] ^ s1_im[N-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_x0_re <= '0;
      bus.o_x0_im <= '0;
      bus.o_x1_re <= '0;
      bus.o_x1_im <= '0;
    end else if (bus.i_en) begin
      bus.o_valid <= d_valid;
      bus.o_x0_re <= post(s0_re);
      bus.o_x0_im <= post(s0_im);
      bus.o_x1_re <= post(s1_re);
      bus.o_x1_im <= post(s1_im);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              bus.o_ovf <= 1'b0;
    else if (bus.i_en && d_valid && sat_any) bus.o_ovf <= 1'b1;
    else if (bus.i_clr_ovf)                  bus.o_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Randomized self-checking bench for fft_butterfly against a sample-level model.
module tb_fft_butterfly;

  localparam int N   = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_butterfly_if #(.N(N)) bus ();

  fft_butterfly #(.N(N), .I(4), .F(4), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { bit v; int re; int im; } samp_t;
  samp_t pipe[$];
  int e_x0r, e_x0i, e_x1r, e_x1i;
  bit e_v, e_ovf;
  int out_cnt;

  function automatic int post(input int s, output bit sat);
    int hi, lo;
    hi  = (1 << (N - 1)) - 1;
    lo  = -(1 << (N - 1));
    sat = 1'b0;
`ifdef FFT_BFLY_SCALE_EN
    return (s + 1) >>> 1;
`else
    if (s > hi) begin sat = 1'b1; return hi; end
    if (s < lo) begin sat = 1'b1; return lo; end
    return s;
`endif
  endfunction

  task automatic model_reset();
    samp_t z;
    z = '{v: 1'b0, re: 0, im: 0};
    pipe.delete();
    repeat (LAT) pipe.push_back(z);
    e_x0r = 0; e_x0i = 0; e_x1r = 0; e_x1i = 0; e_v = 1'b0; e_ovf = 1'b0;
  endtask

  function automatic int sv8(input logic [N-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, "_x0_re"}, sv8(bus.o_x0_re), e_x0r);
    check({pfx, "_x0_im"}, sv8(bus.o_x0_im), e_x0i);
    check({pfx, "_x1_re"}, sv8(bus.o_x1_re), e_x1r);
    check({pfx, "_x1_im"}, sv8(bus.o_x1_im), e_x1i);
    check({pfx, "_valid"}, 32'(bus.o_valid), 32'(e_v));
    check({pfx, "_ovf"},   32'(bus.o_ovf),   32'(e_ovf));
  endtask

  task automatic step(input bit en, input bit v, input logic [N-1:0] ar, input logic [N-1:0] ai,
                      input logic [N-1:0] br, input logic [N-1:0] bi, input bit clr,
                      input string pfx);
    samp_t s, d;
    bit s0, s1, s2, s3, any;
    bus.i_en = en; bus.i_valid = v; bus.i_a_re = ar; bus.i_a_im = ai;
    bus.i_bw_re = br; bus.i_bw_im = bi; bus.i_clr_ovf = clr;
    @(posedge clk);
    #1;
    any = 1'b0;
    d   = '{v: 1'b0, re: 0, im: 0};
    if (en) begin
      s = '{v: v, re: sv8(ar), im: sv8(ai)};
      pipe.push_back(s);
      d = pipe.pop_front();
      e_x0r = post(d.re + sv8(br), s0);
      e_x0i = post(d.im + sv8(bi), s1);
      e_x1r = post(d.re - sv8(br), s2);
      e_x1i = post(d.im - sv8(bi), s3);
      e_v   = d.v;
      any   = s0 | s1 | s2 | s3;
      if (e_v) out_cnt++;
    end
    if (en && d.v && any) e_ovf = 1'b1;
    else if (clr)         e_ovf = 1'b0;
    check_all(pfx);
  endtask

  task automatic bubble(input bit clr, input string pfx);
    step(1'b1, 1'b0, '0, '0, '0, '0, clr, pfx);
  endtask

  function automatic logic [N-1:0] rnd8();
    return N'($urandom_range(0, 255));
  endfunction

  function automatic logic [N-1:0] small8();
    return N'($urandom_range(0, 127) - 64);
  endfunction

  initial begin
    bus.i_en = 1'b0; bus.i_valid = 1'b0; bus.i_clr_ovf = 1'b0;
    bus.i_a_re = '0; bus.i_a_im = '0; bus.i_bw_re = '0; bus.i_bw_im = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_x0_const", 32'(bus.o_x0_re), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic butterfly
    step(1'b1, 1'b1, 8'h10, 8'h20, 8'h00, 8'h00, 1'b0, "t1");
    bubble(1'b0, "t1");
    bubble(1'b0, "t1");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h08, 8'hF8, 1'b0, "t1");
    check("t1_x0_re_c", 32'(bus.o_x0_re), 32'h18);
    check("t1_x0_im_c", 32'(bus.o_x0_im), 32'h18);
    check("t1_x1_re_c", 32'(bus.o_x1_re), 32'h08);
    check("t1_x1_im_c", 32'(bus.o_x1_im), 32'h28);
    check("t1_valid_c", 32'(bus.o_valid), 32'h1);
    bubble(1'b0, "t1");
    check("t1_valid_once", 32'(bus.o_valid), 32'h0);

`ifndef FFT_BFLY_SCALE_EN
    // Saturation and sticky overflow
    step(1'b1, 1'b1, 8'h70, 8'h90, 8'h00, 8'h00, 1'b0, "t2");
    bubble(1'b0, "t2");
    bubble(1'b0, "t2");
    step(1'b1, 1'b1, 8'h70, 8'h90, 8'h70, 8'h90, 1'b0, "t2");
    check("t2_x0_re_c", 32'(bus.o_x0_re), 32'h7F);
    check("t2_x0_im_c", 32'(bus.o_x0_im), 32'h80);
    check("t2_x1_re_c", 32'(bus.o_x1_re), 32'h00);
    check("t2_x1_im_c", 32'(bus.o_x1_im), 32'h00);
    check("t2_ovf_set", 32'(bus.o_ovf), 32'h1);
    bubble(1'b0, "t2");
    bubble(1'b0, "t2");
    check("t2_ovf_sticky", 32'(bus.o_ovf), 32'h1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h70, 8'h90, 1'b1, "t2");
    check("t2_set_wins", 32'(bus.o_ovf), 32'h1);
    bubble(1'b1, "t2");
    check("t2_ovf_clr", 32'(bus.o_ovf), 32'h0);
`else
    // Scaling build
    step(1'b1, 1'b1, 8'h70, 8'h01, 8'h00, 8'h00, 1'b0, "t3");
    bubble(1'b0, "t3");
    bubble(1'b0, "t3");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h70, 8'h00, 1'b0, "t3");
    check("t3_x0_re_c", 32'(bus.o_x0_re), 32'h70);
    check("t3_x0_im_c", 32'(bus.o_x0_im), 32'h01);
    check("t3_x1_re_c", 32'(bus.o_x1_re), 32'h00);
    check("t3_x1_im_c", 32'(bus.o_x1_im), 32'h01);
    check("t3_ovf_c",   32'(bus.o_ovf),   32'h0);
`endif

    // Stall mid-stream
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4)
        repeat (5) step(1'b0, 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, "t4_stall");
      step(1'b1, 1'b1, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, "t4");
    end
    repeat (LAT + 1) step(1'b1, 1'b0, '0, '0, rnd8(), rnd8(), 1'b0, "t4");
    check("t4_count", 32'(out_cnt), 32'd8);

    // Asynchronous reset with samples in flight
    step(1'b1, 1'b1, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, "t5");
    step(1'b1, 1'b1, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0, "t5");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_async");
    #1 rst_n = 1'b1;
    out_cnt = 0;
    repeat (LAT + 2) step(1'b1, 1'b0, '0, '0, rnd8(), rnd8(), 1'b0, "t5_post");
    check("t5_no_stale", 32'(out_cnt), 32'd0);

    // Bubbles carrying large values must not set overflow
    repeat (LAT) bubble(1'b0, "t6");
    bubble(1'b1, "t6");
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 0)
        step(1'b1, 1'b1, small8(), small8(), 8'h7F, 8'h7F, 1'b0, "t6");
      else
        step(1'b1, 1'b0, 8'h7F, 8'h7F, small8(), small8(), 1'b0, "t6");
    end
    repeat (LAT) step(1'b1, 1'b0, '0, '0, small8(), small8(), 1'b0, "t6");
    check("t6_ovf_clean", 32'(bus.o_ovf), 32'h0);

    // Free-running random traffic
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8(), rnd8(),
           1'($urandom_range(0, 15) == 0), "rnd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
